// File: rtl/t_flip_flop_pkg.sv
// Shared constants and types for the T flip-flop bank and its reference model.
package t_flip_flop_pkg;

  localparam int   DEFAULT_WIDTH       = 1;
  localparam logic DEFAULT_RESET_VALUE = 1'b0;

  // Per-bit action as seen by a reference model: T = 1 toggles, T = 0 holds.
  typedef enum logic {
    ACT_HOLD   = 1'b0,
    ACT_TOGGLE = 1'b1
  } t_action_e;

endpackage

// File: rtl/t_flip_flop_bit.sv
// Single-bit T cell: toggles on a rising clock edge when t = 1.
// Reset is asynchronous and active-high, and it loads RESET_VALUE.
module t_flip_flop_bit
  import t_flip_flop_pkg::*;
#(
  parameter logic RESET_VALUE = DEFAULT_RESET_VALUE
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/t_flip_flop.sv
// Bank of WIDTH independent T flip-flops with true and complement outputs.
// Qb_Out is derived from the same state register, so it can never disagree with Q_Out.
module t_flip_flop
  import t_flip_flop_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{DEFAULT_RESET_VALUE}}
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic [WIDTH-1:0] T_In,
  output logic [WIDTH-1:0] Q_Out,
  output logic [WIDTH-1:0] Qb_Out
);

  if (WIDTH < 1) begin : g_bad_width
    $error("t_flip_flop: WIDTH must be at least 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_flip_flop_bit #(
      .RESET_VALUE(RESET_VALUE[i])
    ) u_bit (
      .clk(Clk_In),
      .rst(Reset_In),
      .t  (T_In[i]),
      .q  (Q_Out[i])
    );
  end

  assign Qb_Out = ~Q_Out;

  // Simulation-only sanity checks; synthesis ignores concurrent assertions.
  a_qb_inverse : assert property (@(posedge Clk_In) Qb_Out == ~Q_Out);
  a_reset_value : assert property (@(posedge Clk_In) Reset_In |-> (Q_Out == RESET_VALUE));

endmodule

// File: tb/tb_t_flip_flop.sv
// Directed and table-driven checks of the T flip-flop bank, default and 4-bit configurations.
module tb_t_flip_flop;
  import t_flip_flop_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       t1;
  logic       q1, qb1;
  logic [3:0] t4;
  logic [3:0] q4, qb4;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic  rst;
    logic  t;
    logic  exp_q;
    logic  exp_qb;
    string name;
  } vec_t;

  t_flip_flop dut1 (
    .Clk_In  (clk),
    .Reset_In(rst),
    .T_In    (t1),
    .Q_Out   (q1),
    .Qb_Out  (qb1)
  );

  t_flip_flop #(.WIDTH(4), .RESET_VALUE(4'b1010)) dut4 (
    .Clk_In  (clk),
    .Reset_In(rst),
    .T_In    (t4),
    .Q_Out   (q4),
    .Qb_Out  (qb4)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       vecs[9];
    logic       q_ref;
    t_action_e  act;

    // Reset with T held at 0, then at 1 (reset dominates), then the toggle sequence.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, "reset_t0"};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, "reset_t1"};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, "hold_after_reset"};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, "seq_t1_a"};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, "seq_t0_a"};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, "seq_t1_b"};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, "seq_t1_c"};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, "seq_t1_d"};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, "seq_t0_b"};

    t1  = 1'b0;
    t4  = 4'b0000;
    rst = 1'b1;
    #1;
    check("async_reset_q", {3'b0, q1}, 4'b0000);
    check("async_reset_qb", {3'b0, qb1}, 4'b0001);
    check("async_reset_q4", q4, 4'b1010);
    check("async_reset_qb4", qb4, 4'b0101);

    for (int i = 0; i < 9; i++) begin
      rst = vecs[i].rst;
      t1  = vecs[i].t;
      @(posedge clk);
      #1;
      check({vecs[i].name, "_q"}, {3'b0, q1}, {3'b0, vecs[i].exp_q});
      check({vecs[i].name, "_qb"}, {3'b0, qb1}, {3'b0, vecs[i].exp_qb});
    end

    // Get Q to 1, then pulse reset for 5 ns between edges while T = 1.
    t1 = 1'b1;
    @(posedge clk);
    #1;
    check("pre_pulse_q", {3'b0, q1}, 4'b0001);
    #4;
    rst = 1'b1;
    #1;
    check("mid_cycle_reset_q", {3'b0, q1}, 4'b0000);
    check("mid_cycle_reset_qb", {3'b0, qb1}, 4'b0001);
    #4;
    rst = 1'b0;
    #1;
    check("after_release_q", {3'b0, q1}, 4'b0000);
    @(posedge clk);
    #1;
    check("first_edge_after_release_q", {3'b0, q1}, 4'b0001);

    // Random T against an independent model.
    q_ref = 1'b1;
    for (int i = 0; i < 10; i++) begin
      t1  = 1'($urandom_range(1, 0));
      act = t1 ? ACT_TOGGLE : ACT_HOLD;
      if (act == ACT_TOGGLE) q_ref = ~q_ref;
      @(posedge clk);
      #1;
      check("random_q", {3'b0, q1}, {3'b0, q_ref});
      check("random_qb", {3'b0, qb1}, {3'b0, ~q_ref});
    end
    t1 = 1'b0;

    // The 4-bit bank saw T = 0 throughout and was last reset to 1010.
    check("w4_hold_q", q4, 4'b1010);

    rst = 1'b1;
    #1;
    check("w4_reset_q", q4, 4'b1010);
    check("w4_reset_qb", qb4, 4'b0101);
    @(posedge clk);
    #1;
    rst = 1'b0;
    t4  = 4'b0011;
    @(posedge clk);
    #1;
    check("w4_t0011_q", q4, 4'b1001);
    check("w4_t0011_qb", qb4, 4'b0110);
    t4 = 4'b1111;
    @(posedge clk);
    #1;
    check("w4_t1111_a_q", q4, 4'b0110);
    @(posedge clk);
    #1;
    check("w4_t1111_b_q", q4, 4'b1001);
    check("w4_t1111_b_qb", qb4, 4'b0110);
    t4 = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
